// File: rtl/reg_bank_arbiter_if.sv
// rtl/reg_bank_arbiter_if.sv - requester and bank signal bundle for reg_bank_arbiter
//
// Purpose: groups both requester ports and the bank port of reg_bank_arbiter.
// Ports (signals):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  requester -> arbiter
//   gnt0/gnt1, rvalid0/rvalid1, rdata0/rdata1        arbiter -> requester
//   addr, datain, sig                                arbiter -> bank
//   dataout                                          bank -> arbiter
//   busy                                             arbiter status (clear sweep)
// Modports: slave = arbiter side, master = requester/bank environment side.

interface reg_bank_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 9
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] addr;
    logic [DW-1:0] datain;
    logic          sig;
    logic [DW-1:0] dataout;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dataout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, addr, datain, sig, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dataout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, addr, datain, sig, busy
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-requester round-robin arbiter for a single-port register bank
//
// Purpose: shares one synchronous-read register bank between two requesters.
// One access is issued per ISSUE cycle; reads return data one cycle later.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   reg_bank_arbiter_if.slave (requester and bank signals)
// Optional feature macro: REG_ARB_CLEAR_EN
//   defined   -> after reset a CLEAR sweep writes 0 to every bank address (busy=1)
//   undefined -> no sweep, busy tied low, bank contents untouched by reset

module reg_bank_arbiter #(
    parameter int AW = 8,
    parameter int DW = 9
) (
    input  logic               clk,
    input  logic               rst,
    reg_bank_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1
`ifdef REG_ARB_CLEAR_EN
        , ST_CLEAR = 2'd2
`endif
    } state_t;

`ifdef REG_ARB_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t        state_q,   state_d;
    logic          win_q,     win_d;      // requester being served in ISSUE
    logic          we_q,      we_d;
    logic [AW-1:0] addr_q,    addr_d;     // doubles as the sweep counter in CLEAR
    logic [DW-1:0] datain_q,  datain_d;
    logic          last_q,    last_d;     // last-served requester for tie breaks
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q,  rdata0_d;
    logic [DW-1:0] rdata1_q,  rdata1_d;

    logic gnt0_raw;
    logic gnt1_raw;
    logic elig0;
    logic elig1;
    logic pick1;
    logic clearing;

    // Arbitration: a requester granted in this cycle is still holding its
    // request, so it is excluded until it has had a chance to update it.
    always_comb begin
        gnt0_raw = (state_q == ST_ISSUE) && (win_q == 1'b0);
        gnt1_raw = (state_q == ST_ISSUE) && (win_q == 1'b1);
        elig0    = bus.req0 && !gnt0_raw;
        elig1    = bus.req1 && !gnt1_raw;
        // On a tie the requester not served last wins.
        pick1    = elig1 && (!elig0 || !last_q);
`ifdef REG_ARB_CLEAR_EN
        clearing = (state_q == ST_CLEAR);
`else
        clearing = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        datain_d  = datain_q;
        last_d    = last_q;
        // The bank presents read data the cycle after a read ISSUE.
        rvalid0_d = (state_q == ST_ISSUE) && !we_q && (win_q == 1'b0);
        rvalid1_d = (state_q == ST_ISSUE) && !we_q && (win_q == 1'b1);
        // rdata is passed straight through while rvalid is high and
        // captured at the end of that cycle so it holds afterwards.
        rdata0_d  = rvalid0_q ? bus.dataout : rdata0_q;
        rdata1_d  = rvalid1_q ? bus.dataout : rdata1_q;

        case (state_q)
`ifdef REG_ARB_CLEAR_EN
            ST_CLEAR: begin
                // datain_q is zero from reset, so every sweep cycle writes 0.
                if (addr_q == {AW{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
`endif
            default: begin
                if (elig0 || elig1) begin
                    state_d  = ST_ISSUE;
                    win_d    = pick1;
                    last_d   = pick1;
                    we_d     = pick1 ? bus.we1    : bus.we0;
                    addr_d   = pick1 ? bus.addr1  : bus.addr0;
                    datain_d = pick1 ? bus.wdata1 : bus.wdata0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs are forced to their reset values while rst is high so that an
    // access in flight cannot strobe the bank on the resetting edge.
    always_comb begin
        bus.gnt0    = gnt0_raw && !rst;
        bus.gnt1    = gnt1_raw && !rst;
        bus.sig     = !rst && (((state_q == ST_ISSUE) && we_q) || clearing);
        bus.busy    = !rst && clearing;
        bus.addr    = rst ? '0 : addr_q;
        bus.datain  = rst ? '0 : datain_q;
        bus.rvalid0 = rvalid0_q && !rst;
        bus.rvalid1 = rvalid1_q && !rst;
        bus.rdata0  = rst ? '0 : (rvalid0_q ? bus.dataout : rdata0_q);
        bus.rdata1  = rst ? '0 : (rvalid1_q ? bus.dataout : rdata1_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            datain_q  <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            datain_q  <= datain_d;
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter

module tb_reg_bank_arbiter;

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [8:0] d;
    } op_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    op_t        q0[$];
    op_t        q1[$];
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic [8:0] shadow [256];
    logic [8:0] mem    [256];
    logic [8:0] mon_e0;
    logic [8:0] mon_e1;

    reg_bank_arbiter_if #(.AW(8), .DW(9)) bus ();

    reg_bank_arbiter #(.AW(8), .DW(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read bank model
    always @(posedge clk) begin
        if (bus.sig === 1'b1) mem[bus.addr] <= bus.datain;
        else                  bus.dataout   <= mem[bus.addr];
    end

    // Requester 0: hold the head op until granted, then move on
    always @(negedge clk) begin
        if (bus.req0 === 1'b1 && bus.gnt0 === 1'b1) begin
            void'(q0.pop_front());
            bus.req0 = 1'b0;
        end
        if (bus.req0 !== 1'b1 && q0.size() > 0) begin
            bus.req0   = 1'b1;
            bus.we0    = q0[0].we;
            bus.addr0  = q0[0].a;
            bus.wdata0 = q0[0].d;
        end
    end

    always @(negedge clk) begin
        if (bus.req1 === 1'b1 && bus.gnt1 === 1'b1) begin
            void'(q1.pop_front());
            bus.req1 = 1'b0;
        end
        if (bus.req1 !== 1'b1 && q1.size() > 0) begin
            bus.req1   = 1'b1;
            bus.we1    = q1[0].we;
            bus.addr1  = q1[0].a;
            bus.wdata1 = q1[0].d;
        end
    end

    // Scoreboard: read results and grant exclusivity
    always @(negedge clk) begin
        if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
            checks++;
            if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) begin
                errors++;
                $display("FAIL gnt_onehot: gnt0=%b gnt1=%b, required at most one", bus.gnt0, bus.gnt1);
            end
        end
        if (bus.rvalid0 === 1'b1) begin
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("FAIL rvalid0_unexpected: rdata0=%h, required no rvalid0", bus.rdata0);
            end else begin
                mon_e0 = exp0.pop_front();
                if (bus.rdata0 !== mon_e0) begin
                    errors++;
                    $display("FAIL rdata0: got %h, required %h", bus.rdata0, mon_e0);
                end
            end
        end
        if (bus.rvalid1 === 1'b1) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL rvalid1_unexpected: rdata1=%h, required no rvalid1", bus.rdata1);
            end else begin
                mon_e1 = exp1.pop_front();
                if (bus.rdata1 !== mon_e1) begin
                    errors++;
                    $display("FAIL rdata1: got %h, required %h", bus.rdata1, mon_e1);
                end
            end
        end
    end

    task automatic push_op(input bit r, input bit we, input logic [7:0] a, input logic [8:0] d);
        op_t o;
        o.we = we;
        o.a  = a;
        o.d  = d;
        if (we) shadow[a] = d;
        else if (r) exp1.push_back(shadow[a]);
        else exp0.push_back(shadow[a]);
        if (r) q1.push_back(o);
        else q0.push_back(o);
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 256; i++) shadow[i] = 9'h000;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 &&
                bus.req0 !== 1'b1 && bus.req1 !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [40:0] out_vec();
        return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.sig, bus.busy,
                bus.addr, bus.datain, bus.rdata0, bus.rdata1};
    endfunction

    task automatic test_reset();
        logic [40:0] v;
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        v = out_vec();
        checks++;
        if (v !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
`ifdef REG_ARB_CLEAR_EN
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 1", bus.busy);
        end
        clear_shadow();
        wait_busy_low(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_sweep_timeout: busy still %b, required 0", bus.busy);
        end
`else
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
`endif
    endtask

    task automatic test_single_read();
        logic [5:0] gmask;
        logic [5:0] vmask;
        logic [8:0] rd;
        bit ok;
        push_op(1'b1, 1'b1, 8'h1C, 9'h155);
        wait_idle(50, ok);
        gmask = '0;
        vmask = '0;
        rd    = '0;
        @(posedge clk);
        #1 push_op(1'b0, 1'b0, 8'h1C, 9'h000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.gnt0 === 1'b1) gmask[i] = 1'b1;
            if (bus.rvalid0 === 1'b1) begin
                vmask[i] = 1'b1;
                rd = bus.rdata0;
            end
        end
        checks++;
        if (gmask !== 6'b000010) begin
            errors++;
            $display("FAIL single_read_gnt_timing: got %b, required 000010", gmask);
        end
        checks++;
        if (vmask !== 6'b000100) begin
            errors++;
            $display("FAIL single_read_rvalid_timing: got %b, required 000100", vmask);
        end
        checks++;
        if (rd !== 9'h155) begin
            errors++;
            $display("FAIL single_read_data: got %h, required 155", rd);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rdata0 !== 9'h155) begin
            errors++;
            $display("FAIL rdata0_hold: got %h, required 155", bus.rdata0);
        end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_read_drain: queues not empty, required empty");
        end
    endtask

    task automatic test_crossing();
        int g1i;
        int g0i;
        logic [8:0] rd;
        bit ok;
        g1i = -1;
        g0i = -1;
        rd  = '0;
        @(posedge clk);
        #1 push_op(1'b1, 1'b1, 8'h05, 9'h0AA);
        @(posedge clk);
        #1 push_op(1'b0, 1'b0, 8'h05, 9'h000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.gnt1 === 1'b1 && g1i < 0) g1i = i;
            if (bus.gnt0 === 1'b1 && g0i < 0) g0i = i;
            if (bus.rvalid0 === 1'b1) rd = bus.rdata0;
        end
        checks++;
        if (g1i != 0 || g0i != 1) begin
            errors++;
            $display("FAIL crossing_order: gnt1 at %0d gnt0 at %0d, required 0 and 1", g1i, g0i);
        end
        checks++;
        if (rd !== 9'h0AA) begin
            errors++;
            $display("FAIL crossing_data: got %h, required 0aa", rd);
        end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL crossing_drain: queues not empty, required empty");
        end
    endtask

    task automatic test_stream();
        logic [9:0] gmask;
        bit ok;
        gmask = '0;
        @(posedge clk);
        #1 begin
            push_op(1'b1, 1'b0, 8'h05, 9'h000);
            push_op(1'b1, 1'b0, 8'h1C, 9'h000);
            push_op(1'b1, 1'b0, 8'h05, 9'h000);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.gnt1 === 1'b1) gmask[i] = 1'b1;
        end
        checks++;
        if (gmask !== 10'b0000101010) begin
            errors++;
            $display("FAIL stream_gnt1_pattern: got %b, required 0000101010", gmask);
        end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_drain: queues not empty, required empty");
        end
    endtask

`ifndef REG_ARB_CLEAR_EN
    task automatic test_tie();
        logic [1:0] g;
        logic [1:0] want;
        bit ok;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_op(1'b0, 1'b0, 8'h1C, 9'h000);
            push_op(1'b1, 1'b0, 8'h05, 9'h000);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g    = {bus.gnt1, bus.gnt0};
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (g !== want) begin
                errors++;
                $display("FAIL tie_order[%0d]: {gnt1,gnt0}=%b, required %b", i, g, want);
            end
        end
        wait_idle(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tie_drain: queues not empty, required empty");
        end
    endtask
`endif

    task automatic test_reset_abort();
        logic [40:0] v;
        logic [40:0] want;
        bit seen;
        bit ok;
        seen = 1'b0;
        @(posedge clk);
        #1 push_op(1'b0, 1'b0, 8'h1C, 9'h000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.gnt0 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_gnt_timeout: gnt0 never seen, required within 10 cycles");
        end
        #1 rst = 1'b1;
        exp0.delete();
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.sig} !== 3'b000) begin
            errors++;
            $display("FAIL abort_during_rst: {gnt0,gnt1,sig}=%b, required 000", {bus.gnt0, bus.gnt1, bus.sig});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        v = out_vec();
`ifdef REG_ARB_CLEAR_EN
        want = {6'b000011, 35'd0};
        clear_shadow();
`else
        want = 41'd0;
`endif
        checks++;
        if (v !== want) begin
            errors++;
            $display("FAIL abort_outputs: got %h, required %h", v, want);
        end
`ifdef REG_ARB_CLEAR_EN
        wait_busy_low(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_sweep_timeout: busy still %b, required 0", bus.busy);
        end
`endif
        wait_idle(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_drain: queues not empty, required empty");
        end
    endtask

`ifdef REG_ARB_CLEAR_EN
    task automatic test_clear();
        int cnt;
        int gj;
        bit gnt_busy;
        bit ok;
        push_op(1'b0, 1'b1, 8'h00, 9'h1FF);
        push_op(1'b1, 1'b1, 8'hFF, 9'h101);
        push_op(1'b0, 1'b1, 8'h80, 9'h0F0);
        wait_idle(50, ok);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_shadow();
        cnt      = 0;
        gnt_busy = 1'b0;
        gj       = -1;
        #1;
        for (int i = 0; i < 400; i++) begin
            if (bus.busy !== 1'b1) break;
            cnt++;
            if (bus.gnt0 === 1'b1) gnt_busy = 1'b1;
            if (cnt == 10) push_op(1'b0, 1'b0, 8'h80, 9'h000);
            @(negedge clk);
        end
        for (int j = 1; j < 6; j++) begin
            @(negedge clk);
            if (bus.gnt0 === 1'b1) begin
                gj = j;
                break;
            end
        end
        checks++;
        if (cnt != 256) begin
            errors++;
            $display("FAIL clear_busy_cycles: got %0d, required 256", cnt);
        end
        checks++;
        if (gnt_busy) begin
            errors++;
            $display("FAIL clear_gnt_during_busy: gnt0 seen, required none");
        end
        checks++;
        if (gj != 1) begin
            errors++;
            $display("FAIL clear_first_gnt: after %0d cycles, required 1", gj);
        end
        wait_idle(50, ok);
        for (int a = 0; a < 256; a++) push_op(a[0], 1'b0, a[7:0], 9'h000);
        wait_idle(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clear_readback_drain: queues not empty, required empty");
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        test_reset();
        test_single_read();
        test_crossing();
        test_stream();
`ifndef REG_ARB_CLEAR_EN
        test_tie();
`endif
        test_reset_abort();
`ifdef REG_ARB_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
